// File: rtl/spn_round_engine_if.sv
// Handshake bundle for the SPN round engine.
// Plaintext/key enter on the in_* side; ciphertext leaves on the out_* side.
interface spn_round_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] plaintext;
    logic [31:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ciphertext;

    modport master (
        output in_valid, plaintext, key, out_ready,
        input  in_ready, out_valid, ciphertext
    );

    modport slave (
        input  in_valid, plaintext, key, out_ready,
        output in_ready, out_valid, ciphertext
    );
endinterface

// File: rtl/spn_round_engine.sv
// Iterative 16-bit SPN cipher: one shared S/P round datapath, one round per clock.
// Ciphertext is held in DONE until the consumer takes it.
module spn_round_engine #(
    parameter int NUM_ROUNDS = 4
) (
    input logic clk,
    input logic reset,
    spn_round_engine_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    localparam logic [2:0] LAST_RND  = 3'(NUM_ROUNDS - 1);
    localparam logic [2:0] FINAL_KEY = 3'(NUM_ROUNDS);

    state_t      state, state_nx;
    logic [15:0] w, w_nx;
    logic [31:0] key_q, key_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [15:0] mixed, subbed, rnd_out;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hA;
            4'h1: y = 4'h5;
            4'h2: y = 4'h8;
            4'h3: y = 4'h2;
            4'h4: y = 4'h6;
            4'h5: y = 4'hC;
            4'h6: y = 4'h4;
            4'h7: y = 4'h3;
            4'h8: y = 4'h1;
            4'h9: y = 4'h0;
            4'hA: y = 4'hB;
            4'hB: y = 4'h9;
            4'hC: y = 4'hF;
            4'hD: y = 4'hD;
            4'hE: y = 4'h7;
            default: y = 4'hE;
        endcase
        return y;
    endfunction

    function automatic logic [15:0] sub16(input logic [15:0] x);
        logic [15:0] y;
        for (int n = 0; n < 4; n++)
            y[4*n +: 4] = sbox(x[4*n +: 4]);
        return y;
    endfunction

    // Nibble j of the result gathers bit j of every input nibble.
    function automatic logic [15:0] perm16(input logic [15:0] x);
        logic [15:0] y;
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 4; k++)
                y[4*j + k] = x[4*k + j];
        return y;
    endfunction

    function automatic logic [15:0] round_key(
        input logic [31:0] k,
        input logic [2:0]  i
    );
        logic [15:0] rk;
        unique case (i)
            3'd0: rk = k[31:16];
            3'd1: rk = k[27:12];
            3'd2: rk = k[23:8];
            3'd3: rk = k[19:4];
            3'd4: rk = k[15:0];
            default: rk = 16'h0000;
        endcase
        return rk;
    endfunction

    assign mixed   = w ^ round_key(key_q, cnt);
    assign subbed  = sub16(mixed);
    assign rnd_out = (cnt == LAST_RND)
                   ? (subbed ^ round_key(key_q, FINAL_KEY))
                   : perm16(subbed);

    always_comb begin
        state_nx = state;
        w_nx     = w;
        key_nx   = key_q;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_nx     = bus.plaintext;
                    key_nx   = bus.key;
                    cnt_nx   = 3'd0;
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                w_nx   = rnd_out;
                cnt_nx = cnt + 3'd1;
                if (cnt == LAST_RND)
                    state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            w     <= 16'h0000;
            key_q <= 32'h0000_0000;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            w     <= w_nx;
            key_q <= key_nx;
            cnt   <= cnt_nx;
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.ciphertext = w;
endmodule

// File: tb/tb_spn_round_engine.sv
// Bench for spn_round_engine: 4-round and 1-round instances against a
// behavioural cipher model, with directed vectors, stalls, resets and streaming.
module tb_spn_round_engine;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spn_round_engine_if bus4();
    spn_round_engine_if bus1();

    spn_round_engine #(.NUM_ROUNDS(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    spn_round_engine #(.NUM_ROUNDS(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit [3:0] sbox_tab [16] = '{4'hA, 4'h5, 4'h8, 4'h2, 4'h6, 4'hC, 4'h4, 4'h3,
                                4'h1, 4'h0, 4'hB, 4'h9, 4'hF, 4'hD, 4'h7, 4'hE};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_enc(input logic [15:0] pt,
                                            input logic [31:0] k,
                                            input int nr);
        logic [15:0] w, s, p;
        logic [31:0] sh;
        w = pt;
        for (int r = 0; r < nr; r++) begin
            sh = k >> (16 - 4 * r);
            w  = w ^ sh[15:0];
            for (int n = 0; n < 4; n++)
                s[4*n +: 4] = sbox_tab[w[4*n +: 4]];
            if (r == nr - 1) begin
                sh = k >> (16 - 4 * nr);
                w  = s ^ sh[15:0];
            end else begin
                for (int j = 0; j < 4; j++)
                    for (int b = 0; b < 4; b++)
                        p[4*j + b] = s[4*b + j];
                w = p;
            end
        end
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic blk4(input logic [15:0] pt, input logic [31:0] k,
                        input int hold, input bit toggle,
                        input logic [15:0] exp);
        int lat;
        lat = 0;
        while (!bus4.in_ready && lat < 20) begin
            step();
            lat++;
        end
        chk("b4_idle_rdy", 32'(bus4.in_ready), 1);
        bus4.in_valid  = 1'b1;
        bus4.plaintext = pt;
        bus4.key       = k;
        bus4.out_ready = 1'b0;
        step();
        bus4.in_valid = toggle;
        lat = 0;
        while (!bus4.out_valid && lat < 20) begin
            chk("b4_busy_rdy", 32'(bus4.in_ready), 0);
            if (toggle) begin
                bus4.plaintext = 16'($urandom);
                bus4.key       = $urandom;
            end
            step();
            lat++;
        end
        chk("b4_latency", 32'(lat), 4);
        chk("b4_ct", 32'(bus4.ciphertext), 32'(exp));
        for (int h = 0; h < hold; h++) begin
            if (toggle) begin
                bus4.plaintext = 16'($urandom);
                bus4.key       = $urandom;
            end
            step();
            chk("b4_hold_vld", 32'(bus4.out_valid), 1);
            chk("b4_hold_ct", 32'(bus4.ciphertext), 32'(exp));
            chk("b4_hold_rdy", 32'(bus4.in_ready), 0);
        end
        bus4.out_ready = 1'b1;
        bus4.in_valid  = 1'b0;
        step();
        bus4.out_ready = 1'b0;
        chk("b4_ret_rdy", 32'(bus4.in_ready), 1);
        chk("b4_ret_vld", 32'(bus4.out_valid), 0);
    endtask

    task automatic blk1(input logic [15:0] pt, input logic [31:0] k,
                        input logic [15:0] exp);
        int lat;
        bus1.in_valid  = 1'b1;
        bus1.plaintext = pt;
        bus1.key       = k;
        bus1.out_ready = 1'b0;
        step();
        bus1.in_valid = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("b1_latency", 32'(lat), 1);
        chk("b1_ct", 32'(bus1.ciphertext), 32'(exp));
        bus1.out_ready = 1'b1;
        step();
        bus1.out_ready = 1'b0;
        chk("b1_ret_rdy", 32'(bus1.in_ready), 1);
    endtask

    initial begin
        logic [15:0] pt, q[$];
        logic [31:0] k;
        int last, cyc, got;

        reset = 1'b1;
        bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
        bus4.plaintext = '0;  bus4.key = '0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
        bus1.plaintext = '0;  bus1.key = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_rdy", 32'(bus4.in_ready), 1);
        chk("rst_vld", 32'(bus4.out_valid), 0);
        chk("rst_ct", 32'(bus4.ciphertext), 0);
        chk("rst1_rdy", 32'(bus1.in_ready), 1);

        // Known-answer vectors
        blk4(16'h0000, 32'h0000_0000, 10, 1'b0, 16'hEBE6);
        blk1(16'h1234, 32'h1234_5678, 16'h89EF);

        // Inputs churn while busy; result must follow the accepted pair
        pt = 16'hBEEF;
        k  = 32'hC0FF_EE42;
        blk4(pt, k, 3, 1'b1, ref_enc(pt, k, 4));

        for (int i = 0; i < 8; i++) begin
            pt = 16'($urandom);
            k  = $urandom;
            blk4(pt, k, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)),
                 ref_enc(pt, k, 4));
        end
        for (int i = 0; i < 4; i++) begin
            pt = 16'($urandom);
            k  = $urandom;
            blk1(pt, k, ref_enc(pt, k, 1));
        end

        // Reset in the second ROUND cycle drops the block
        bus4.in_valid  = 1'b1;
        bus4.plaintext = 16'hA5A5;
        bus4.key       = 32'h1357_9BDF;
        step();
        bus4.in_valid = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rmid_rdy", 32'(bus4.in_ready), 1);
        chk("rmid_vld", 32'(bus4.out_valid), 0);
        chk("rmid_ct", 32'(bus4.ciphertext), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("rmid_novld", 32'(bus4.out_valid), 0);
        end

        // Reset while holding DONE
        bus4.in_valid  = 1'b1;
        bus4.plaintext = 16'h0F0F;
        bus4.key       = 32'hFFFF_0000;
        step();
        bus4.in_valid = 1'b0;
        repeat (4) step();
        chk("rdone_pre_vld", 32'(bus4.out_valid), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rdone_vld", 32'(bus4.out_valid), 0);
        chk("rdone_ct", 32'(bus4.ciphertext), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rdone_novld", 32'(bus4.out_valid), 0);
        end

        // Reset beats a simultaneous handshake
        reset = 1'b1;
        bus4.in_valid  = 1'b1;
        bus4.plaintext = 16'h7777;
        step();
        reset = 1'b0;
        bus4.in_valid = 1'b0;
        chk("rprio_rdy", 32'(bus4.in_ready), 1);
        step();
        chk("rprio_rdy2", 32'(bus4.in_ready), 1);
        chk("rprio_ct", 32'(bus4.ciphertext), 0);

        // Streaming with both handshakes tied high
        last = -1;
        cyc  = 0;
        got  = 0;
        bus4.in_valid  = 1'b1;
        bus4.out_ready = 1'b1;
        while (got < 12 && cyc < 200) begin
            bus4.plaintext = 16'($urandom);
            bus4.key       = $urandom;
            if (bus4.in_ready)
                q.push_back(ref_enc(bus4.plaintext, bus4.key, 4));
            if (bus4.out_valid) begin
                if (q.size() == 0)
                    chk("b2b_unexpected", 32'(bus4.ciphertext), 32'hFFFF_FFFF);
                else
                    chk("b2b_ct", 32'(bus4.ciphertext), 32'(q.pop_front()));
                if (last >= 0)
                    chk("b2b_gap", 32'(cyc - last), 6);
                last = cyc;
                got++;
            end
            step();
            cyc++;
        end
        chk("b2b_count", 32'(got), 12);
        bus4.in_valid = 1'b0;
        repeat (8) step();
        bus4.out_ready = 1'b0;
        chk("b2b_end_rdy", 32'(bus4.in_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spn_round_engine.md
SPN_ROUND_ENGINE -- requirements
Module: spn_round_engine

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 4, meaning the number of SPN rounds per block, with legal range 1..4.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning a plaintext/key pair is offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the engine can accept a pair this cycle.
REQ-006 The block SHALL have port plaintext, input, 16 bits, the block to encrypt.
REQ-007 The block SHALL have port key, input, 32 bits, the cipher key.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning ciphertext is held valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the ciphertext.
REQ-010 The block SHALL have port ciphertext, output, 16 bits, the encrypted block.

Function
REQ-011 Round key k_i, for i = 0..NUM_ROUNDS, SHALL be key[31-4i -: 16] of the latched key, so k0=key[31:16], k1=key[27:12] and k4=key[15:0].
REQ-012 S(x) SHALL substitute each nibble independently with the map 0..F -> A,5,8,2,6,C,4,3,1,0,B,9,F,D,7,E.
REQ-013 P(x) SHALL be the 4x4 bit transpose out[4j+k] = in[4k+j], for j,k = 0..3.
REQ-014 For rounds r = 1..NUM_ROUNDS-1, the state update SHALL be w <= P(S(w ^ k_{r-1})).
REQ-015 The final round SHALL compute w <= S(w ^ k_{NUM_ROUNDS-1}) ^ k_{NUM_ROUNDS}, with no permutation.
REQ-016 The engine SHALL be iterative, using one shared S/P datapath and executing exactly one round per clock.
REQ-017 The FSM SHALL have states IDLE, ROUND and DONE.
REQ-018 In IDLE, in_ready=1 and out_valid=0; when in_valid=1, the engine SHALL latch plaintext into w, latch key, clear the round counter to 0, and go to ROUND.
REQ-019 In ROUND, the engine SHALL apply one round per cycle and increment the counter; after round NUM_ROUNDS completes, it SHALL go to DONE.
REQ-020 In DONE, out_valid SHALL be 1 and ciphertext SHALL equal w; when out_ready=1, the engine SHALL return to IDLE.
REQ-021 If out_ready=0 in DONE, ciphertext and out_valid SHALL hold stable indefinitely.
REQ-022 Latency: for a handshake accepted at edge t, out_valid SHALL first be 1 in the cycle after edge t+NUM_ROUNDS.
REQ-023 Throughput: the minimum spacing between accepted blocks SHALL be NUM_ROUNDS+2 cycles.
REQ-024 in_ready SHALL be 0 in ROUND and DONE; in_valid in those states SHALL be ignored, and plaintext/key changes SHALL not affect the block in flight.
REQ-025 in_ready SHALL be a pure function of state, with no combinational path from in_valid or out_ready.
REQ-026 The round counter SHALL be 3 bits wide and never exceed NUM_ROUNDS.
REQ-027 ciphertext SHALL be driven from the w register only, with no combinational path from inputs.

Reset
REQ-028 On reset=1 at a clock edge, state SHALL become IDLE, and w, the latched key and the counter SHALL become 0.
REQ-029 The reset values SHALL give in_ready=1, out_valid=0 and ciphertext=0x0000 in the following cycle.
REQ-030 Reset SHALL take priority over any handshake in the same cycle.
REQ-031 Reset asserted mid-ROUND or in DONE SHALL discard the block in flight, with no out_valid pulse afterwards.

Verification
REQ-032 Scenario: NUM_ROUNDS=4, key=0x00000000, plaintext=0x0000 -> ciphertext=0xEBE6, with out_valid first 1 in the cycle after edge t+4.
REQ-033 Scenario: NUM_ROUNDS=1, key=0x12345678, plaintext=0x1234 -> ciphertext=0x89EF (S(0x0000)^0x2345), with out_valid in the cycle after edge t+1.
REQ-034 Scenario: DONE is held with out_ready=0 for 10 cycles -> out_valid=1 and ciphertext is unchanged throughout; out_ready=1 -> IDLE and in_ready=1 in the next cycle.
REQ-035 Scenario: in_valid held high and key/plaintext toggled every cycle during ROUND -> result equals the vector captured at acceptance; in_ready=0 until return to IDLE.
REQ-036 Scenario: reset pulsed during the second ROUND cycle -> next cycle in_ready=1, out_valid=0, ciphertext=0x0000, and no later out_valid.
REQ-037 Scenario: back-to-back blocks with out_ready tied to 1 and in_valid tied to 1 -> one result every 6 cycles (NUM_ROUNDS=4), each matching a reference model of REQ-011..015.
